// File: rtl/spw_link_fsm_gen_if.sv
// Signal bundle between the SpaceWire link-state controller and its surroundings:
// link control levels, asynchronous RX status strobes and the registered TX/status outputs.
interface spw_link_fsm_gen_if #(
  parameter int RETRY_W = 4
);
  logic               auto_start;
  logic               link_start;
  logic               link_disable;
  logic               link_clear;
  logic               rx_error;
  logic               rx_credit_error;
  logic               rx_got_bit;
  logic               rx_got_null;
  logic               rx_got_nchar;
  logic               rx_got_time_code;
  logic               rx_got_fct;
  logic               rx_resetn;
  logic               enable_tx;
  logic               send_null_tx;
  logic               send_fct_tx;
  logic               link_running;
  logic [2:0]         fsm_state;
  logic [2:0]         err_cause;
  logic               err_pulse;
  logic [RETRY_W-1:0] retry_cnt;

  modport master (
    output auto_start, link_start, link_disable, link_clear,
    output rx_error, rx_credit_error, rx_got_bit, rx_got_null,
    output rx_got_nchar, rx_got_time_code, rx_got_fct,
    input  rx_resetn, enable_tx, send_null_tx, send_fct_tx, link_running,
    input  fsm_state, err_cause, err_pulse, retry_cnt
  );

  modport slave (
    input  auto_start, link_start, link_disable, link_clear,
    input  rx_error, rx_credit_error, rx_got_bit, rx_got_null,
    input  rx_got_nchar, rx_got_time_code, rx_got_fct,
    output rx_resetn, enable_tx, send_null_tx, send_fct_tx, link_running,
    output fsm_state, err_cause, err_pulse, retry_cnt
  );
endinterface

// File: rtl/spw_link_fsm_gen.sv
// Parametrised SpaceWire link-state controller with cycle-count timeouts, RX synchronisers,
// error-cause reporting and a retry counter that can lock the link out after repeated failures.
module spw_link_fsm_gen #(
  parameter int RESET_CYCLES = 640,
  parameter int WAIT_CYCLES  = 1280,
  parameter int DISC_CYCLES  = 85,
  parameter int CNT_W        = 12,
  parameter int SYNC_STAGES  = 2,
  parameter int RETRY_W      = 4,
  parameter int RETRY_MAX    = 0
) (
  input logic                pclk,
  input logic                resetn,
  spw_link_fsm_gen_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_ERROR_RESET = 3'd0,
    ST_ERROR_WAIT  = 3'd1,
    ST_READY       = 3'd2,
    ST_STARTED     = 3'd3,
    ST_CONNECTING  = 3'd4,
    ST_RUN         = 3'd5,
    ST_LOCKED      = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0]   RESET_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   WAIT_LAST  = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DISC_LAST  = CNT_W'(DISC_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM  = RETRY_W'(RETRY_MAX);
  localparam logic [RETRY_W-1:0] RETRY_SAT  = {RETRY_W{1'b1}};

  // Highest-priority error code among the conditions raised this cycle (0 = none).
  function automatic logic [2:0] pick_cause(input logic rx, input logic cr, input logic sq,
                                            input logic dc, input logic tm, input logic ds);
    if (rx)      return 3'd1;
    else if (cr) return 3'd3;
    else if (sq) return 3'd2;
    else if (dc) return 3'd4;
    else if (tm) return 3'd5;
    else if (ds) return 3'd6;
    else         return 3'd0;
  endfunction

  logic [6:0] rx_raw_s;
  logic [6:0] sync_r [SYNC_STAGES];
  logic [6:0] rx_s;

  assign rx_raw_s = {bus.rx_error, bus.rx_credit_error, bus.rx_got_bit, bus.rx_got_null,
                     bus.rx_got_nchar, bus.rx_got_time_code, bus.rx_got_fct};

  // RX status synchroniser chain, one vector per stage.
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= 7'd0;
    end else begin
      sync_r[0] <= rx_raw_s;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  assign rx_s = sync_r[SYNC_STAGES-1];

  logic rx_error_s, credit_s, got_bit_s, got_null_s, got_nchar_s, got_tc_s, got_fct_s;
  assign {rx_error_s, credit_s, got_bit_s, got_null_s, got_nchar_s, got_tc_s, got_fct_s} = rx_s;

  state_t             state_r, adv_s, next_s;
  logic [CNT_W-1:0]   timer_r, disc_r;
  logic [RETRY_W-1:0] retry_r;
  logic [2:0]         cause_r, cause_s;
  logic               pulse_r, rx_resetn_r, enable_tx_r, send_null_r, send_fct_r, running_r;
  logic               f_rx_s, f_cr_s, f_seq_s, f_disc_s, f_tmo_s, f_dis_s;
  logic               err_exit_s, retry_inc_s, lock_due_s, wait_done_s;

  assign lock_due_s  = (RETRY_MAX != 0) && (retry_r == RETRY_LIM);
  assign wait_done_s = (timer_r == WAIT_LAST);

  // Per-state advance target and error conditions; any error overrides the advance.
  always_comb begin
    adv_s    = state_r;
    f_rx_s   = 1'b0;
    f_cr_s   = 1'b0;
    f_seq_s  = 1'b0;
    f_disc_s = 1'b0;
    f_tmo_s  = 1'b0;
    f_dis_s  = 1'b0;
    case (state_r)
      ST_ERROR_RESET: adv_s = (timer_r == RESET_LAST) ? ST_ERROR_WAIT : ST_ERROR_RESET;
      ST_ERROR_WAIT: begin
        f_rx_s  = rx_error_s;
        f_seq_s = got_fct_s | got_nchar_s | got_tc_s;
        if (wait_done_s) adv_s = lock_due_s ? ST_LOCKED : ST_READY;
        else             adv_s = ST_ERROR_WAIT;
      end
      ST_READY: begin
        f_rx_s  = rx_error_s;
        f_seq_s = got_fct_s | got_nchar_s | got_tc_s;
        adv_s   = (!bus.link_disable && (bus.link_start || (bus.auto_start && got_null_s)))
                  ? ST_STARTED : ST_READY;
      end
      ST_STARTED: begin
        f_rx_s  = rx_error_s;
        f_seq_s = got_fct_s | got_nchar_s | got_tc_s;
        f_tmo_s = wait_done_s;
        adv_s   = got_null_s ? ST_CONNECTING : ST_STARTED;
      end
      ST_CONNECTING: begin
        f_rx_s  = rx_error_s;
        f_seq_s = got_nchar_s | got_tc_s;
        f_tmo_s = wait_done_s;
        adv_s   = got_fct_s ? ST_RUN : ST_CONNECTING;
      end
      ST_RUN: begin
        f_rx_s   = rx_error_s;
        f_cr_s   = credit_s;
        f_disc_s = !got_bit_s && (disc_r == DISC_LAST);
        f_dis_s  = bus.link_disable;
        adv_s    = ST_RUN;
      end
      ST_LOCKED: adv_s = bus.link_clear ? ST_ERROR_RESET : ST_LOCKED;
      default:   adv_s = ST_ERROR_RESET;
    endcase
    err_exit_s  = f_rx_s | f_cr_s | f_seq_s | f_disc_s | f_tmo_s | f_dis_s;
    cause_s     = pick_cause(f_rx_s, f_cr_s, f_seq_s, f_disc_s, f_tmo_s, f_dis_s);
    next_s      = err_exit_s ? ST_ERROR_RESET : adv_s;
    retry_inc_s = err_exit_s &&
                  (state_r == ST_STARTED || state_r == ST_CONNECTING || state_r == ST_RUN);
  end

  // State, timers, retry/cause bookkeeping and outputs decoded from the next state.
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_ERROR_RESET;
      timer_r     <= {CNT_W{1'b0}};
      disc_r      <= {CNT_W{1'b0}};
      retry_r     <= {RETRY_W{1'b0}};
      cause_r     <= 3'd0;
      pulse_r     <= 1'b0;
      rx_resetn_r <= 1'b0;
      enable_tx_r <= 1'b0;
      send_null_r <= 1'b0;
      send_fct_r  <= 1'b0;
      running_r   <= 1'b0;
    end else begin
      state_r <= next_s;
      timer_r <= (next_s != state_r) ? {CNT_W{1'b0}} : timer_r + CNT_W'(1'b1);
      disc_r  <= (state_r == ST_RUN && next_s == ST_RUN && !got_bit_s)
                 ? disc_r + CNT_W'(1'b1) : {CNT_W{1'b0}};
      // link_clear outranks a simultaneous increment
      if (bus.link_clear)                                retry_r <= {RETRY_W{1'b0}};
      else if (retry_inc_s)                              retry_r <= (retry_r == RETRY_SAT) ? retry_r : retry_r + RETRY_W'(1'b1);
      else if (next_s == ST_RUN && state_r != ST_RUN)    retry_r <= {RETRY_W{1'b0}};
      else if (state_r == ST_READY && bus.link_disable)  retry_r <= {RETRY_W{1'b0}};
      else                                               retry_r <= retry_r;
      if (err_exit_s)          cause_r <= cause_s;
      else if (bus.link_clear) cause_r <= 3'd0;
      else                     cause_r <= cause_r;
      pulse_r     <= err_exit_s;
      rx_resetn_r <= !(next_s == ST_ERROR_RESET || next_s == ST_LOCKED);
      enable_tx_r <= (next_s == ST_READY) || (next_s == ST_STARTED) ||
                     (next_s == ST_CONNECTING) || (next_s == ST_RUN);
      send_null_r <= (next_s == ST_STARTED) || (next_s == ST_CONNECTING) || (next_s == ST_RUN);
      send_fct_r  <= (next_s == ST_CONNECTING) || (next_s == ST_RUN);
      running_r   <= (next_s == ST_RUN);
    end
  end

  assign bus.fsm_state    = state_r;
  assign bus.err_cause    = cause_r;
  assign bus.err_pulse    = pulse_r;
  assign bus.retry_cnt    = retry_r;
  assign bus.rx_resetn    = rx_resetn_r;
  assign bus.enable_tx    = enable_tx_r;
  assign bus.send_null_tx = send_null_r;
  assign bus.send_fct_tx  = send_fct_r;
  assign bus.link_running = running_r;

endmodule
